// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader: RV32I opcodes, command types and FSM states.
package instr_encoder_loader_pkg;

    // Same opcode set the single-cycle core's control decoder recognises.
    localparam logic [6:0] OPC_R    = 7'd51;
    localparam logic [6:0] OPC_LW   = 7'd3;
    localparam logic [6:0] OPC_I    = 7'd19;
    localparam logic [6:0] OPC_S    = 7'd35;
    localparam logic [6:0] OPC_B    = 7'd99;
    localparam logic [6:0] OPC_J    = 7'd111;
    localparam logic [6:0] OPC_U    = 7'd55;
    localparam logic [6:0] OPC_JALR = 7'd103;

    localparam logic [2:0] F3_LW_SW = 3'b010;
    localparam logic [2:0] F3_JALR  = 3'b000;
    localparam logic [2:0] F3_SRX   = 3'b101;

    typedef enum logic [2:0] {
        CMD_R    = 3'd0,
        CMD_I    = 3'd1,
        CMD_LW   = 3'd2,
        CMD_SW   = 3'd3,
        CMD_B    = 3'd4,
        CMD_J    = 3'd5,
        CMD_LUI  = 3'd6,
        CMD_JALR = 3'd7
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Command handshake (field-level instruction) plus instruction-memory write bus.
interface instr_encoder_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_type;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output cmd_valid, cmd_type, funct3, funct7b5, rd, rs1, rs2, imm,
        input  cmd_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_type, funct3, funct7b5, rd, rs1, rs2, imm,
        output cmd_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_format_packer.sv
// Combinational packer: command fields -> RV32I word. range_ok exists only when
// INSTR_ENCODER_RANGE_CHECK_EN is defined.
module instr_format_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [2:0]  cmd_type,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    ,
    output logic        range_ok
`endif
);

    logic [6:0] f7;
    assign f7 = {1'b0, funct7b5, 5'b00000};

    always_comb begin
        word = '0;
        case (cmd_type_e'(cmd_type))
            CMD_R:    word = {f7, rs2, rs1, funct3, rd, OPC_R};
            CMD_I: begin
                // Shift-right immediates carry the arithmetic/logical select in bit 30.
                if (funct3 == F3_SRX)
                    word = {f7, imm[4:0], rs1, funct3, rd, OPC_I};
                else
                    word = {imm[11:0], rs1, funct3, rd, OPC_I};
            end
            CMD_LW:   word = {imm[11:0], rs1, F3_LW_SW, rd, OPC_LW};
            CMD_SW:   word = {imm[11:5], rs2, rs1, F3_LW_SW, imm[4:0], OPC_S};
            CMD_B:    word = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], OPC_B};
            CMD_J:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_J};
            CMD_LUI:  word = {imm[31:12], rd, OPC_U};
            CMD_JALR: word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
            default:  word = '0;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        range_ok = 1'b1;
        case (cmd_type_e'(cmd_type))
            CMD_I, CMD_LW, CMD_SW, CMD_JALR: range_ok = fits12;
            CMD_B:   range_ok = fits13 & ~imm[0];
            CMD_J:   range_ok = fits21 & ~imm[0];
            CMD_LUI: range_ok = ~(|imm[11:0]);
            default: range_ok = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes field-level commands into RV32I words and writes them sequentially to instruction
// memory. Define INSTR_ENCODER_RANGE_CHECK_EN to reject out-of-range immediates (err pulse).
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    instr_encoder_loader_if.slave  bus,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   err
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [31:0]     addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [31:0]     packed_word;
    logic            range_ok;
    logic            cmd_ready, mem_we;

    instr_format_packer u_packer (
        .cmd_type (bus.cmd_type),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .rd       (bus.rd),
        .rs1      (bus.rs1),
        .rs2      (bus.rs2),
        .imm      (bus.imm),
        .word     (packed_word)
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        ,
        .range_ok (range_ok)
`endif
    );

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic err_reg, err_next;
`else
    assign range_ok = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cmd_ready  = 1'b0;
        mem_we     = 1'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        err_next   = 1'b0;
`endif
        // clear outranks everything: it kills a pending write and blocks the handshake.
        if (clear) begin
            state_next = ST_IDLE;
            count_next = '0;
            addr_next  = BASE_ADDR;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (bus.cmd_valid) begin
                        if (range_ok) begin
                            wdata_next = packed_word;
                            state_next = ST_WRITE;
                        end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                        else begin
                            err_next = 1'b1;
                        end
`endif
                    end
                end
                ST_WRITE: begin
                    mem_we    = 1'b1;
                    addr_next = addr_reg + 32'd4;
                    if (count_reg != DEPTH_C)
                        count_next = count_reg + CW'(1);
                    state_next = ((count_reg + CW'(1)) == DEPTH_C) ? ST_FULL : ST_IDLE;
                end
                ST_FULL: begin
                    state_next = ST_FULL;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            addr_reg  <= BASE_ADDR;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_reg <= 1'b0;
        else     err_reg <= err_next;
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign count         = count_reg;
    assign full          = (count_reg == DEPTH_C);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=4): directed encodings, random commands
// against an arithmetic encoding model, fill/clear, and reset/clear during a write.
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instr_encoder_loader_if bus();

    instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus),
        .count (count),
        .full  (full),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    // Reference encoding built field by field with shifts and masks.
    function automatic logic [31:0] model_word(input int unsigned t, f3, f7b5, rd, rs1, rs2,
                                               input logic [31:0] imm);
        int unsigned i, w, hi7;
        i   = imm;
        hi7 = f7b5 << 5;
        case (t)
            0: w = 51 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (hi7 << 25);
            1: begin
                w = 19 | (rd << 7) | (f3 << 12) | (rs1 << 15);
                if (f3 == 5) w = w | ((i & 31) << 20) | (hi7 << 25);
                else         w = w | ((i & 'hFFF) << 20);
            end
            2: w = 3 | (rd << 7) | (2 << 12) | (rs1 << 15) | ((i & 'hFFF) << 20);
            3: w = 35 | ((i & 31) << 7) | (2 << 12) | (rs1 << 15) | (rs2 << 20)
                   | (((i >> 5) & 127) << 25);
            4: w = 99 | ((((i >> 11) & 1) | (((i >> 1) & 15) << 1)) << 7) | (f3 << 12)
                   | (rs1 << 15) | (rs2 << 20) | (((i >> 5) & 63) << 25)
                   | (((i >> 12) & 1) << 31);
            5: w = 111 | (rd << 7) | (((i >> 12) & 255) << 12) | (((i >> 11) & 1) << 20)
                   | (((i >> 1) & 1023) << 21) | (((i >> 20) & 1) << 31);
            6: w = 55 | (rd << 7) | (i & 32'hFFFF_F000);
            default: w = 103 | (rd << 7) | (rs1 << 15) | ((i & 'hFFF) << 20);
        endcase
        return w;
    endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    function automatic bit model_accept(input int unsigned t, input logic [31:0] imm);
        int s;
        s = int'(imm);
        case (t)
            0:       return 1'b1;
            4:       return (imm[0] == 1'b0) && (s >= -4096) && (s <= 4095);
            5:       return (imm[0] == 1'b0) && (s >= -(1 << 20)) && (s < (1 << 20));
            6:       return (imm[11:0] == 12'h000);
            default: return (s >= -2048) && (s <= 2047);
        endcase
    endfunction
`endif

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake edge.
    task automatic send_cmd(input int t, f3, f7b5, rd, rs1, rs2, input logic [31:0] imm,
                            output bit hs);
        hs = 1'b0;
        bus.cmd_type  = t[2:0];
        bus.funct3    = f3[2:0];
        bus.funct7b5  = f7b5[0];
        bus.rd        = rd[4:0];
        bus.rs1       = rs1[4:0];
        bus.rs2       = rs2[4:0];
        bus.imm       = imm;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                hs = 1'b1;
            end
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (!hs) begin
            miscompares++;
            $display("FAIL handshake_timeout: cmd_ready=%b required 1 within 20 cycles",
                     bus.cmd_ready);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 ||
            count !== '0 || full !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: we=%b addr=%h wdata=%h count=%0d full=%b err=%b required 0 0 0 0 0 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, count, full, err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset released, outputs at reset values checked");
    endtask

    typedef struct {
        int          t, f3, f7b5, rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        bit          clr;
    } vec_t;

    task automatic test_directed();
        vec_t tab[8];
        int   mcount;
        logic [31:0] mptr;
        bit   hs;
        tab[0] = '{0, 0, 0, 3, 1, 2, 32'd0,         32'h002081B3, 1'b1};
        tab[1] = '{0, 0, 1, 3, 1, 2, 32'd0,         32'h402081B3, 1'b0};
        tab[2] = '{1, 0, 0, 1, 0, 0, 32'd5,         32'h00500093, 1'b1};
        tab[3] = '{2, 0, 0, 5, 2, 0, 32'd8,         32'h00812283, 1'b0};
        tab[4] = '{3, 0, 0, 0, 2, 5, 32'd12,        32'h00512623, 1'b0};
        tab[5] = '{4, 0, 0, 0, 1, 2, -32'sd8,       32'hFE208CE3, 1'b1};
        tab[6] = '{5, 0, 0, 1, 0, 0, 32'd16,        32'h010000EF, 1'b0};
        tab[7] = '{6, 0, 0, 5, 0, 0, 32'h12345000,  32'h123452B7, 1'b0};
        mcount = 0;
        mptr   = 32'h0;
        for (int n = 0; n < 8; n++) begin
            if (tab[n].clr) begin
                do_clear();
                mcount = 0;
                mptr   = 32'h0;
            end
            send_cmd(tab[n].t, tab[n].f3, tab[n].f7b5, tab[n].rd, tab[n].rs1, tab[n].rs2,
                     tab[n].imm, hs);
            @(negedge clk);
            vectors++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== mptr || bus.mem_wdata !== tab[n].exp) begin
                miscompares++;
                $display("FAIL directed_%0d: we=%b addr=%h wdata=%h required we=1 addr=%h wdata=%h",
                         n, bus.mem_we, bus.mem_addr, bus.mem_wdata, mptr, tab[n].exp);
            end
            @(posedge clk);
            #1;
            mcount++;
            mptr += 4;
            @(negedge clk);
            vectors++;
            if (count !== CW'(mcount) || bus.mem_we !== 1'b0 || bus.mem_addr !== mptr) begin
                miscompares++;
                $display("FAIL directed_after_%0d: count=%0d we=%b addr=%h required count=%0d we=0 addr=%h",
                         n, count, bus.mem_we, bus.mem_addr, mcount, mptr);
            end
            $display("directed %0d: type=%0d word=%h addr=%h", n, tab[n].t, tab[n].exp, mptr - 4);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int          t, f3, f7b5, rd, rs1, rs2, mcount;
        logic [31:0] imm, exp, mptr;
        bit          hs, acc;
        do_clear();
        mcount = 0;
        mptr   = 32'h0;
        for (int n = 0; n < 40; n++) begin
            t    = $urandom_range(0, 7);
            f3   = $urandom_range(0, 7);
            f7b5 = $urandom_range(0, 1);
            rd   = $urandom_range(0, 31);
            rs1  = $urandom_range(0, 31);
            rs2  = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) imm = $urandom;
            else                          imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            exp = model_word(t, f3, f7b5, rd, rs1, rs2, imm);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
            acc = model_accept(t, imm);
`else
            acc = 1'b1;
`endif
            send_cmd(t, f3, f7b5, rd, rs1, rs2, imm, hs);
            @(negedge clk);
            vectors++;
            if (acc) begin
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== mptr || bus.mem_wdata !== exp
                    || err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random_%0d: type=%0d imm=%h we=%b addr=%h wdata=%h err=%b required we=1 addr=%h wdata=%h err=0",
                             n, t, imm, bus.mem_we, bus.mem_addr, bus.mem_wdata, err, mptr, exp);
                end
            end else begin
                if (bus.mem_we !== 1'b0 || err !== 1'b1) begin
                    miscompares++;
                    $display("FAIL random_reject_%0d: type=%0d imm=%h we=%b err=%b required we=0 err=1",
                             n, t, imm, bus.mem_we, err);
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                mcount++;
                mptr += 4;
            end
            @(negedge clk);
            vectors++;
            if (count !== CW'(mcount) || full !== (mcount == DEPTH) || bus.mem_addr !== mptr
                || err !== 1'b0) begin
                miscompares++;
                $display("FAIL random_state_%0d: count=%0d full=%b addr=%h err=%b required count=%0d full=%b addr=%h err=0",
                         n, count, full, bus.mem_addr, err, mcount, (mcount == DEPTH), mptr);
            end
            $display("random %0d: type=%0d imm=%h accept=%b word=%h", n, t, imm, acc, exp);
            @(posedge clk);
            #1;
            if (mcount == DEPTH) begin
                do_clear();
                mcount = 0;
                mptr   = 32'h0;
            end
        end
    endtask

    task automatic test_full();
        do_clear();
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.cmd_type  = 3'd1;
        bus.funct3    = 3'd0;
        bus.funct7b5  = 1'b0;
        bus.rd        = 5'd1;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.imm       = 32'd5;
        bus.cmd_valid = 1'b1;
        repeat (14) @(negedge clk);
        vectors++;
        if (wr_addr_q.size() != DEPTH || full !== 1'b1 || bus.cmd_ready !== 1'b0 ||
            count !== CW'(DEPTH)) begin
            miscompares++;
            $display("FAIL full_fill: writes=%0d full=%b ready=%b count=%0d required writes=%0d full=1 ready=0 count=%0d",
                     wr_addr_q.size(), full, bus.cmd_ready, count, DEPTH, DEPTH);
        end
        for (int k = 0; k < wr_addr_q.size(); k++) begin
            vectors++;
            if (wr_addr_q[k] !== 32'(4 * k) || wr_data_q[k] !== 32'h00500093) begin
                miscompares++;
                $display("FAIL full_write_%0d: addr=%h wdata=%h required addr=%h wdata=00500093",
                         k, wr_addr_q[k], wr_data_q[k], 32'(4 * k));
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_clear_ready: ready=%b required 0", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== '0 || bus.mem_addr !== 32'h0 || bus.cmd_ready !== 1'b1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL full_after_clear: count=%0d addr=%h ready=%b full=%b required 0 0 1 0",
                     count, bus.mem_addr, bus.cmd_ready, full);
        end
        $display("full: %0d writes then clear", wr_addr_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort_write();
        bit hs;
        // clear during the WRITE cycle
        do_clear();
        send_cmd(0, 0, 0, 3, 1, 2, 32'd0, hs);
        clear = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_mid_write_we: we=%b required 0", bus.mem_we);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== '0 || bus.mem_addr !== 32'h0 || bus.cmd_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_mid_write_state: count=%0d addr=%h ready=%b we=%b required 0 0 1 0",
                     count, bus.mem_addr, bus.cmd_ready, bus.mem_we);
        end
        $display("clear mid-write: write aborted");
        @(posedge clk);
        #1;
        // reset during the WRITE cycle
        wr_addr_q.delete();
        wr_data_q.delete();
        send_cmd(6, 0, 0, 5, 0, 0, 32'h12345000, hs);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b0 || count !== '0 || bus.mem_addr !== 32'h0 ||
            bus.mem_wdata !== 32'h0 || err !== 1'b0 || wr_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_write: we=%b count=%0d addr=%h wdata=%h err=%b writes=%0d required all 0",
                     bus.mem_we, count, bus.mem_addr, bus.mem_wdata, err, wr_addr_q.size());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset mid-write: write suppressed");
        // clear blocks a same-cycle handshake
        bus.cmd_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_blocks_ready: ready=%b required 0", bus.cmd_ready);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b0 || count !== '0) begin
            miscompares++;
            $display("FAIL clear_blocks_hs: we=%b count=%0d required we=0 count=0", bus.mem_we, count);
        end
        $display("clear blocked same-cycle handshake");
        @(posedge clk);
        #1;
    endtask

    task automatic test_range_check();
        bit hs;
        do_clear();
        send_cmd(4, 0, 0, 0, 1, 2, -32'sd7, hs);
        @(negedge clk);
        vectors++;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (bus.mem_we !== 1'b0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_odd_reject: we=%b err=%b required we=0 err=1", bus.mem_we, err);
        end
`else
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hFE208CE3 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL beq_odd_write: we=%b wdata=%h err=%b required we=1 wdata=fe208ce3 err=0",
                     bus.mem_we, bus.mem_wdata, err);
        end
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (count !== '0 || err !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_odd_after: count=%0d err=%b ready=%b required 0 0 1", count, err, bus.cmd_ready);
        end
`else
        if (count !== CW'(1) || err !== 1'b0 || bus.mem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL beq_odd_after: count=%0d err=%b addr=%h required 1 0 00000004",
                     count, err, bus.mem_addr);
        end
`endif
        $display("beq imm=-7: count=%0d", count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 3'd0;
        bus.funct3    = 3'd0;
        bus.funct7b5  = 1'b0;
        bus.rd        = 5'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.imm       = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_full();
        test_abort_write();
        test_range_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
